// File: rtl/l2_stream_pointer.sv
// Pointer/credit controller for one L2 prefetch stream.
// Issues host line requests into a ring of l2_ncl URAM slots, counts in-order responses
// and hands URAM slot pointers to the L1 reader.
module l2_stream_pointer #(
  parameter int unsigned addr_width   = 64,
  parameter int unsigned l2_ncl       = 256,
  parameter int unsigned l2_ncl_width = $clog2(l2_ncl),
  parameter int unsigned cl_bytes     = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rst_v,
  output logic                    i_rst_r,
  input  logic [addr_width-1:0]   i_rst_ea_b,
  input  logic [addr_width-1:0]   i_rst_ea_e,
  output logic                    o_rst_v,
  input  logic                    o_rst_r,
  output logic                    o_rst_end,
  input  logic                    i_rd_v,
  output logic                    i_rd_r,
  output logic                    o_addr_v,
  input  logic                    o_addr_r,
  output logic [l2_ncl_width-1:0] o_addr_ptr,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r
);

  localparam int unsigned cnt_width = l2_ncl_width + 1;
  localparam logic [addr_width-1:0] line_mask = ~(addr_width'(cl_bytes - 1));
  localparam logic [addr_width-1:0] line_step = addr_width'(cl_bytes);
  localparam logic [cnt_width-1:0]  ring_size = cnt_width'(l2_ncl);

  logic                  active;
  logic [addr_width-1:0] cur_ea;
  logic [addr_width-1:0] end_ea;
  logic [cnt_width-1:0]  req_cnt;
  logic [cnt_width-1:0]  rsp_cnt;
  logic [cnt_width-1:0]  rd_cnt;

  logic [cnt_width-1:0]  outstanding;
  logic [cnt_width-1:0]  avail;
  logic [cnt_width-1:0]  used;
  logic [addr_width-1:0] ea_b_line;
  logic [addr_width-1:0] ea_e_line;
  logic                  new_has_lines;
  logic                  rst_xfer;
  logic                  req_xfer;
  logic                  rsp_xfer;
  logic                  rd_xfer;

  // Credit arithmetic and handshake readiness; a reset being accepted masks reads and requests
  // so no host request escapes into a stream whose counters are about to be cleared.
  always_comb begin
    outstanding   = req_cnt - rsp_cnt;
    avail         = rsp_cnt - rd_cnt;
    used          = req_cnt - rd_cnt;
    ea_b_line     = i_rst_ea_b & line_mask;
    ea_e_line     = i_rst_ea_e & line_mask;
    new_has_lines = ea_e_line > ea_b_line;
    i_rst_r       = (outstanding == '0) && !o_rst_v;
    rst_xfer      = i_rst_v && i_rst_r;
    o_req_v       = active && (cur_ea < end_ea) && (used < ring_size) && !rst_xfer;
    i_rsp_r       = outstanding != '0;
    i_rd_r        = (avail != '0) && (!o_addr_v || o_addr_r) && !rst_xfer;
    req_xfer      = o_req_v && o_req_r;
    rsp_xfer      = i_rsp_v && i_rsp_r;
    rd_xfer       = i_rd_v && i_rd_r;
  end

  // Stream state, counters and the notification / URAM address output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active     <= 1'b0;
      cur_ea     <= '0;
      end_ea     <= '0;
      req_cnt    <= '0;
      rsp_cnt    <= '0;
      rd_cnt     <= '0;
      o_rst_v    <= 1'b0;
      o_rst_end  <= 1'b0;
      o_addr_v   <= 1'b0;
      o_addr_ptr <= '0;
    end else begin
      if (rst_xfer) begin
        cur_ea    <= ea_b_line;
        end_ea    <= ea_e_line;
        req_cnt   <= '0;
        rsp_cnt   <= '0;
        rd_cnt    <= '0;
        active    <= new_has_lines;
        o_rst_v   <= 1'b1;
        o_rst_end <= !new_has_lines;
      end else begin
        if (o_rst_v && o_rst_r) begin
          o_rst_v <= 1'b0;
        end
        if (req_xfer) begin
          req_cnt <= req_cnt + cnt_width'(1);
          cur_ea  <= cur_ea + line_step;
        end
        if (rsp_xfer) begin
          rsp_cnt <= rsp_cnt + cnt_width'(1);
        end
        if (rd_xfer) begin
          rd_cnt <= rd_cnt + cnt_width'(1);
        end
      end
      if (rd_xfer) begin
        o_addr_v   <= 1'b1;
        o_addr_ptr <= rd_cnt[l2_ncl_width-1:0];
      end else if (o_addr_r) begin
        o_addr_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l2_stream_pointer.sv
// Self-checking bench for l2_stream_pointer: directed scenarios plus randomized streams,
// checked against a line-count / ring-slot reference model.
module tb_l2_stream_pointer;
  localparam int unsigned AW  = 64;
  localparam int unsigned NCL = 256;
  localparam int unsigned NW  = 8;
  localparam int unsigned CLB = 128;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          i_rst_v    = 1'b0;
  logic          i_rst_r;
  logic [AW-1:0] i_rst_ea_b = '0;
  logic [AW-1:0] i_rst_ea_e = '0;
  logic          o_rst_v;
  logic          o_rst_r    = 1'b1;
  logic          o_rst_end;
  logic          i_rd_v     = 1'b0;
  logic          i_rd_r;
  logic          o_addr_v;
  logic          o_addr_r   = 1'b1;
  logic [NW-1:0] o_addr_ptr;
  logic          o_req_v;
  logic          o_req_r    = 1'b1;
  logic          i_rsp_v;
  logic          i_rsp_r;

  logic rsp_en = 1'b0;
  int   pend   = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   req_seen = 0;
  int   rsp_seen = 0;
  int   rd_seen  = 0;
  logic [NW-1:0] beat_ptrs[$];
  int   base_req = 0;
  int   base_rsp = 0;
  int   base_rd  = 0;
  int   base_beat = 0;

  assign i_rsp_v = rsp_en && (pend != 0);

  l2_stream_pointer #(
    .addr_width(AW), .l2_ncl(NCL), .l2_ncl_width(NW), .cl_bytes(CLB)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_ea_b(i_rst_ea_b), .i_rst_ea_e(i_rst_ea_e),
    .o_rst_v(o_rst_v), .o_rst_r(o_rst_r), .o_rst_end(o_rst_end),
    .i_rd_v(i_rd_v), .i_rd_r(i_rd_r),
    .o_addr_v(o_addr_v), .o_addr_r(o_addr_r), .o_addr_ptr(o_addr_ptr),
    .o_req_v(o_req_v), .o_req_r(o_req_r),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r)
  );

  always #5 clk = ~clk;

  // Host model: every accepted request becomes one pending in-order response.
  always @(posedge clk) begin
    if (!reset) pend <= 0;
    else pend <= pend + ((o_req_v && o_req_r) ? 1 : 0) - ((i_rsp_v && i_rsp_r) ? 1 : 0);
  end

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (o_req_v && o_req_r) req_seen <= req_seen + 1;
      if (i_rsp_v && i_rsp_r) rsp_seen <= rsp_seen + 1;
      if (i_rd_v && i_rd_r)   rd_seen  <= rd_seen + 1;
      if (o_addr_v && o_addr_r) beat_ptrs.push_back(o_addr_ptr);
    end
  end

  function automatic int line_count(input logic [AW-1:0] b, input logic [AW-1:0] e);
    logic [AW-1:0] lb;
    logic [AW-1:0] le;
    lb = b / CLB;
    le = e / CLB;
    return (le > lb) ? int'(le - lb) : 0;
  endfunction

  function automatic int exp_reqs(input int lines, input int reads);
    return (lines < reads + int'(NCL)) ? lines : reads + int'(NCL);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [AW-1:0] b, input logic [AW-1:0] e, output bit accepted);
    accepted = 1'b0;
    i_rd_v = 1'b0;
    for (int c = 0; c < 4000 && !i_rst_r; c++) tick();
    if (i_rst_r) begin
      i_rst_ea_b = b;
      i_rst_ea_e = e;
      i_rst_v = 1'b1;
      tick();
      i_rst_v = 1'b0;
      accepted = 1'b1;
    end
    base_req = req_seen;
    base_rsp = rsp_seen;
    base_rd = rd_seen;
    base_beat = beat_ptrs.size();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    vectors++; if (o_req_v !== 1'b0 || o_addr_v !== 1'b0 || o_rst_v !== 1'b0) begin
      miscompares++; $display("FAIL reset_held_valids: req %b addr %b rst %b, want 0 0 0", o_req_v, o_addr_v, o_rst_v); end
    reset = 1'b1;
    tick();
    vectors++; if (i_rst_r !== 1'b1) begin miscompares++; $display("FAIL reset_rst_ready: got %b want 1", i_rst_r); end
    vectors++; if (i_rd_r !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ready: got %b want 0", i_rd_r); end
    vectors++; if (o_addr_ptr !== '0) begin miscompares++; $display("FAIL reset_ptr: got %0d want 0", o_addr_ptr); end
    vectors++; if (i_rsp_r !== 1'b0 || o_rst_end !== 1'b0) begin
      miscompares++; $display("FAIL reset_misc: rsp_r %b rst_end %b want 0 0", i_rsp_r, o_rst_end); end
    i_rd_v = 1'b1;
    tick();
    i_rd_v = 1'b0;
    vectors++; if (o_addr_v !== 1'b0) begin miscompares++; $display("FAIL reset_idle_read: addr_v %b want 0", o_addr_v); end
  endtask

  task automatic test_fill();
    bit acc;
    int lines;
    rsp_en = 1'b0;
    lines = line_count(64'd32768, 64'd65536);
    start_stream(64'd32768, 64'd65536, acc);
    vectors++; if (acc !== 1'b1 || o_rst_v !== 1'b1) begin
      miscompares++; $display("FAIL fill_notify: accepted %b rst_v %b want 1 1", acc, o_rst_v); end
    vectors++; if (o_rst_end !== 1'b0) begin miscompares++; $display("FAIL fill_rst_end: got %b want 0", o_rst_end); end
    repeat (300) tick();
    vectors++; if (req_seen - base_req != exp_reqs(lines, 0)) begin
      miscompares++; $display("FAIL fill_req_count: got %0d want %0d", req_seen - base_req, exp_reqs(lines, 0)); end
    vectors++; if (o_req_v !== 1'b0 || o_rst_v !== 1'b0) begin
      miscompares++; $display("FAIL fill_stopped: req_v %b rst_v %b want 0 0", o_req_v, o_rst_v); end
  endtask

  task automatic test_reads();
    rsp_en = 1'b1;
    repeat (12) tick();
    rsp_en = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      vectors++; if (i_rd_r !== 1'b1) begin miscompares++; $display("FAIL rd_ready_%0d: got %b want 1", k, i_rd_r); end
      i_rd_v = 1'b1;
      tick();
      i_rd_v = 1'b0;
      vectors++; if (o_addr_v !== 1'b1 || o_addr_ptr !== NW'(k)) begin
        miscompares++; $display("FAIL rd_beat_%0d: v %b ptr %0d want 1 %0d", k, o_addr_v, o_addr_ptr, k); end
      tick();
      vectors++; if (o_addr_v !== 1'b0) begin miscompares++; $display("FAIL rd_single_%0d: v %b want 0", k, o_addr_v); end
    end
    repeat (20) tick();
    vectors++; if (req_seen - base_req != exp_reqs(line_count(64'd32768, 64'd65536), 2)) begin
      miscompares++; $display("FAIL rd_req_count: got %0d want %0d", req_seen - base_req,
                              exp_reqs(line_count(64'd32768, 64'd65536), 2)); end
  endtask

  task automatic test_busy_reset();
    vectors++; if (i_rst_r !== 1'b0) begin miscompares++; $display("FAIL busy_rst_ready: got %b want 0", i_rst_r); end
    i_rst_ea_b = 64'd384;
    i_rst_ea_e = 64'd38400;
    i_rst_v = 1'b1;
    tick();
    i_rst_v = 1'b0;
    vectors++; if (o_rst_v !== 1'b0) begin miscompares++; $display("FAIL busy_rst_dropped: rst_v %b want 0", o_rst_v); end
    repeat (5) tick();
    vectors++; if (o_req_v !== 1'b0 || req_seen - base_req != 256) begin
      miscompares++; $display("FAIL busy_no_restart: req_v %b reqs %0d want 0 256", o_req_v, req_seen - base_req); end
    vectors++; if (i_rd_r !== 1'b1) begin miscompares++; $display("FAIL busy_rd_ready: got %b want 1", i_rd_r); end
    i_rd_v = 1'b1;
    tick();
    i_rd_v = 1'b0;
    vectors++; if (o_addr_v !== 1'b1 || o_addr_ptr !== NW'(2)) begin
      miscompares++; $display("FAIL busy_ptr_kept: v %b ptr %0d want 1 2", o_addr_v, o_addr_ptr); end
  endtask

  task automatic test_drain();
    bit acc;
    int lines;
    int n;
    int bad;
    rsp_en = 1'b1;
    for (int c = 0; c < 2000 && pend != 0; c++) tick();
    vectors++; if (pend != 0) begin miscompares++; $display("FAIL drain_rsp_timeout: pending %0d want 0", pend); end
    lines = line_count(64'd512, 64'd65536);
    start_stream(64'd512, 64'd65536, acc);
    vectors++; if (acc !== 1'b1 || o_rst_end !== 1'b0) begin
      miscompares++; $display("FAIL drain_notify: accepted %b rst_end %b want 1 0", acc, o_rst_end); end
    i_rd_v = 1'b1;
    for (int c = 0; c < 6000 && beat_ptrs.size() - base_beat < lines; c++) tick();
    repeat (3) tick();
    n = beat_ptrs.size() - base_beat;
    bad = -1;
    for (int k = 0; k < n; k++) if (bad < 0 && beat_ptrs[base_beat + k] !== NW'(k % NCL)) bad = k;
    vectors++; if (n != lines) begin miscompares++; $display("FAIL drain_beats: got %0d want %0d", n, lines); end
    vectors++; if (bad >= 0) begin
      miscompares++; $display("FAIL drain_ptr_seq: beat %0d got %0d want %0d", bad, beat_ptrs[base_beat + bad], bad % NCL); end
    vectors++; if (req_seen - base_req != lines) begin
      miscompares++; $display("FAIL drain_reqs: got %0d want %0d", req_seen - base_req, lines); end
    vectors++; if (i_rd_r !== 1'b0 || o_addr_v !== 1'b0) begin
      miscompares++; $display("FAIL drain_exhausted: rd_r %b addr_v %b want 0 0", i_rd_r, o_addr_v); end
    i_rd_v = 1'b0;
  endtask

  task automatic test_empty_stream();
    bit acc;
    rsp_en = 1'b1;
    start_stream(64'd4096, 64'd4096, acc);
    vectors++; if (acc !== 1'b1 || o_rst_v !== 1'b1 || o_rst_end !== 1'b1) begin
      miscompares++; $display("FAIL empty_notify: acc %b rst_v %b rst_end %b want 1 1 1", acc, o_rst_v, o_rst_end); end
    i_rd_v = 1'b1;
    tick();
    vectors++; if (o_req_v !== 1'b0 || i_rd_r !== 1'b0) begin
      miscompares++; $display("FAIL empty_idle: req_v %b rd_r %b want 0 0", o_req_v, i_rd_r); end
    repeat (5) tick();
    i_rd_v = 1'b0;
    vectors++; if (req_seen - base_req != 0 || beat_ptrs.size() - base_beat != 0) begin
      miscompares++; $display("FAIL empty_activity: reqs %0d beats %0d want 0 0", req_seen - base_req,
                              beat_ptrs.size() - base_beat); end
  endtask

  task automatic test_random_streams();
    for (int it = 0; it < 5; it++) begin
      bit acc;
      logic [AW-1:0] b;
      logic [AW-1:0] e;
      logic [AW-1:0] ab;
      int lines;
      int n;
      int bad;
      int viol;
      b = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 100000))};
      ab = (b / CLB) * CLB;
      n = int'($urandom_range(0, 300));
      if (n == 0 && b[31:0] > 32'd1000 && $urandom_range(0, 1) == 1) e = b - 64'($urandom_range(0, 900));
      else e = ab + 64'(n) * 64'(CLB) + 64'($urandom_range(0, 127));
      lines = line_count(b, e);
      o_addr_r = 1'b1;
      rsp_en = 1'b1;
      repeat (2) tick();
      start_stream(b, e, acc);
      vectors++; if (acc !== 1'b1 || o_rst_end !== (lines == 0)) begin
        miscompares++; $display("FAIL rand%0d_notify: acc %b rst_end %b want 1 %b", it, acc, o_rst_end, lines == 0); end
      viol = 0;
      for (int c = 0; c < 8000; c++) begin
        i_rd_v = 1'($urandom_range(0, 1));
        rsp_en = ($urandom_range(0, 2) != 0);
        o_addr_r = ($urandom_range(0, 3) != 0);
        tick();
        if (req_seen - base_req > rd_seen - base_rd + int'(NCL)) viol++;
        if (rd_seen - base_rd > rsp_seen - base_rsp) viol++;
        if (beat_ptrs.size() - base_beat == lines && req_seen - base_req == lines && pend == 0) break;
      end
      o_addr_r = 1'b1;
      rsp_en = 1'b1;
      i_rd_v = 1'b1;
      repeat (3) tick();
      i_rd_v = 1'b0;
      n = beat_ptrs.size() - base_beat;
      bad = -1;
      for (int k = 0; k < n; k++) if (bad < 0 && beat_ptrs[base_beat + k] !== NW'(k % NCL)) bad = k;
      vectors++; if (n != lines || rd_seen - base_rd != lines) begin
        miscompares++; $display("FAIL rand%0d_reads: beats %0d reads %0d want %0d", it, n, rd_seen - base_rd, lines); end
      vectors++; if (req_seen - base_req != lines) begin
        miscompares++; $display("FAIL rand%0d_reqs: got %0d want %0d", it, req_seen - base_req, lines); end
      vectors++; if (bad >= 0) begin
        miscompares++; $display("FAIL rand%0d_ptr_seq: beat %0d got %0d want %0d", it, bad, beat_ptrs[base_beat + bad], bad % NCL); end
      vectors++; if (viol != 0) begin miscompares++; $display("FAIL rand%0d_credit: violations %0d want 0", it, viol); end
      vectors++; if (i_rd_r !== 1'b0) begin miscompares++; $display("FAIL rand%0d_exhausted: rd_r %b want 0", it, i_rd_r); end
    end
  endtask

  task automatic test_midstream_reset();
    bit acc;
    int n;
    int bad;
    rsp_en = 1'b1;
    start_stream(64'd0, 64'd65536, acc);
    i_rd_v = 1'b1;
    repeat (40) tick();
    vectors++; if (acc !== 1'b1 || req_seen - base_req == 0) begin
      miscompares++; $display("FAIL mid_running: acc %b reqs %0d want 1 >0", acc, req_seen - base_req); end
    reset = 1'b0;
    tick();
    vectors++; if (o_req_v !== 1'b0 || o_addr_v !== 1'b0 || o_rst_v !== 1'b0 || i_rsp_r !== 1'b0) begin
      miscompares++; $display("FAIL mid_valids: req %b addr %b rst %b rsp_r %b want 0 0 0 0", o_req_v, o_addr_v, o_rst_v, i_rsp_r); end
    vectors++; if (i_rd_r !== 1'b0 || o_addr_ptr !== '0 || i_rst_r !== 1'b1) begin
      miscompares++; $display("FAIL mid_state: rd_r %b ptr %0d rst_r %b want 0 0 1", i_rd_r, o_addr_ptr, i_rst_r); end
    reset = 1'b1;
    i_rd_v = 1'b0;
    tick();
    start_stream(64'd0, 64'd1280, acc);
    i_rd_v = 1'b1;
    for (int c = 0; c < 500 && beat_ptrs.size() - base_beat < 10; c++) tick();
    repeat (3) tick();
    i_rd_v = 1'b0;
    n = beat_ptrs.size() - base_beat;
    bad = -1;
    for (int k = 0; k < n; k++) if (bad < 0 && beat_ptrs[base_beat + k] !== NW'(k)) bad = k;
    vectors++; if (acc !== 1'b1 || n != 10 || req_seen - base_req != 10) begin
      miscompares++; $display("FAIL mid_restart: acc %b beats %0d reqs %0d want 1 10 10", acc, n, req_seen - base_req); end
    vectors++; if (bad >= 0) begin
      miscompares++; $display("FAIL mid_ptr_seq: beat %0d got %0d want %0d", bad, beat_ptrs[base_beat + bad], bad); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reads();
    test_busy_reset();
    test_drain();
    test_empty_stream();
    test_random_streams();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
